seg7_scan_driver: RTL and testbench

Parametrised multiplexed seven-segment scan driver. It is the next-generation display back end for the register-file and processor boards. It time-multiplexes DIGITS hex digits onto one shared active-low segment bus with per-digit active-low anodes, and adds features the first-generation controller lacks:

- double-buffered, frame-synchronous data load;
- per-digit decimal points and blanking;
- leading-zero suppression;
- 4-bit PWM brightness.

---
 rtl/seg7_pkg.sv | 15 +
 rtl/seg7_glyph.sv | 11 +
 rtl/seg7_scan_driver.sv | 131 +++++++++++++
 tb/tb_seg7_scan_driver.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared constants and glyph table for the seven-segment scan driver
package seg7_pkg;

    localparam int STEP_W = 4;
    localparam logic [6:0] SEG_OFF = 7'h7F;

    // Active-low segment patterns, bit 6 = a ... bit 0 = g, indexed by hex value.
    localparam logic [6:0] GLYPHS [16] = '{
        7'h01, 7'h4F, 7'h12, 7'h06,
        7'h4C, 7'h24, 7'h20, 7'h0F,
        7'h00, 7'h04, 7'h08, 7'h60,
        7'h31, 7'h42, 7'h30, 7'h38
    };

endpackage

// File: rtl/seg7_glyph.sv
// rtl/seg7_glyph.sv - combinational hex nibble to active-low segment pattern
module seg7_glyph
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg_n
);

    assign seg_n = GLYPHS[nibble];

endmodule

// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - multiplexed seven-segment scan driver with buffering, blanking and PWM
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int DIGITS   = 8,
    parameter int TICK_DIV = 6510
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [4*DIGITS-1:0]   data_in,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic [DIGITS-1:0]     blank_in,
    input  logic                  lz_en,
    input  logic [3:0]            bright,
    input  logic                  load,
    output logic                  frame_start,
    output logic [DIGITS-1:0]     anode_n,
    output logic [6:0]            seg_n,
    output logic                  dp_n
);

    localparam int TICK_W = $clog2(TICK_DIV);
    localparam int DIG_W  = $clog2(DIGITS);

    logic [TICK_W-1:0] tick_cnt;
    logic [STEP_W-1:0] step;
    logic [DIG_W-1:0]  dig;
    logic              tick;
    logic              step_wrap;
    logic              frame_bnd;

    logic [4*DIGITS-1:0] act_data;
    logic [DIGITS-1:0]   act_dp;
    logic [DIGITS-1:0]   act_blank;
    logic [4*DIGITS-1:0] pend_data;
    logic [DIGITS-1:0]   pend_dp;
    logic [DIGITS-1:0]   pend_blank;
    logic                pend;

    logic [DIGITS-1:0] dark;
    logic              all_zero;
    logic [3:0]        sel_nib;
    logic [6:0]        sel_seg;
    logic              sel_lit;

    assign tick      = (tick_cnt == TICK_W'(TICK_DIV - 1));
    assign step_wrap = tick && (step == '1);
    assign frame_bnd = step_wrap && (dig == DIG_W'(DIGITS - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tick_cnt <= '0;
            step     <= '0;
            dig      <= '0;
        end else begin
            if (tick) begin
                tick_cnt <= '0;
                step     <= step + 1'b1;
            end else begin
                tick_cnt <= tick_cnt + 1'b1;
            end
            if (step_wrap) begin
                dig <= frame_bnd ? '0 : dig + 1'b1;
            end
        end
    end

    // A load landing exactly on the boundary bypasses pending so it shows this frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            act_data   <= '0;
            act_dp     <= '0;
            act_blank  <= '0;
            pend_data  <= '0;
            pend_dp    <= '0;
            pend_blank <= '0;
            pend       <= 1'b0;
        end else if (load && frame_bnd) begin
            act_data  <= data_in;
            act_dp    <= dp_in;
            act_blank <= blank_in;
            pend      <= 1'b0;
        end else begin
            if (frame_bnd && pend) begin
                act_data  <= pend_data;
                act_dp    <= pend_dp;
                act_blank <= pend_blank;
                pend      <= 1'b0;
            end
            if (load) begin
                pend_data  <= data_in;
                pend_dp    <= dp_in;
                pend_blank <= blank_in;
                pend       <= 1'b1;
            end
        end
    end

    // Scan from the most significant digit down so all_zero covers digits i..DIGITS-1.
    always_comb begin
        all_zero = 1'b1;
        dark     = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            all_zero = all_zero & (act_data[4*i +: 4] == 4'h0);
            dark[i]  = act_blank[i] | (lz_en & all_zero & (i > 0));
        end
    end

    assign sel_nib = act_data[{dig, 2'b00} +: 4];
    assign sel_lit = (step != '0) && (step <= bright) && !dark[dig];

    seg7_glyph u_glyph (
        .nibble (sel_nib),
        .seg_n  (sel_seg)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            anode_n     <= '1;
            seg_n       <= SEG_OFF;
            dp_n        <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            anode_n     <= sel_lit ? ~(DIGITS'(1) << dig) : '1;
            seg_n       <= sel_lit ? sel_seg : SEG_OFF;
            dp_n        <= ~(sel_lit & act_dp[dig]);
            frame_start <= frame_bnd;
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb/tb_seg7_scan_driver.sv - self-checking bench for seg7_scan_driver with a cycle-count reference model
module tb_seg7_scan_driver;

    localparam int ND    = 4;
    localparam int TD    = 2;
    localparam int SLOT  = 16 * TD;
    localparam int FRAME = ND * SLOT;

    logic          clk;
    logic          reset;
    logic [15:0]   data_in;
    logic [3:0]    dp_in;
    logic [3:0]    blank_in;
    logic          lz_en;
    logic [3:0]    bright;
    logic          load;
    logic          frame_start;
    logic [3:0]    anode_n;
    logic [6:0]    seg_n;
    logic          dp_n;

    int total = 0;
    int bad   = 0;

    seg7_scan_driver #(.DIGITS(ND), .TICK_DIV(TD)) dut (
        .clk         (clk),
        .reset       (reset),
        .data_in     (data_in),
        .dp_in       (dp_in),
        .blank_in    (blank_in),
        .lz_en       (lz_en),
        .bright      (bright),
        .load        (load),
        .frame_start (frame_start),
        .anode_n     (anode_n),
        .seg_n       (seg_n),
        .dp_n        (dp_n)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] ref_glyph(input logic [3:0] n);
        case (n)
            4'h0: return 7'b0000001;  4'h1: return 7'b1001111;
            4'h2: return 7'b0010010;  4'h3: return 7'b0000110;
            4'h4: return 7'b1001100;  4'h5: return 7'b0100100;
            4'h6: return 7'b0100000;  4'h7: return 7'b0001111;
            4'h8: return 7'b0000000;  4'h9: return 7'b0000100;
            4'hA: return 7'b0001000;  4'hB: return 7'b1100000;
            4'hC: return 7'b0110001;  4'hD: return 7'b1000010;
            4'hE: return 7'b0110000;  default: return 7'b0111000;
        endcase
    endfunction

    function automatic logic [3:0] nib(input logic [15:0] v, input int d);
        return 4'(v >> (4 * d));
    endfunction

    function automatic logic ref_dark(input int d, input logic [15:0] v,
                                      input logic [3:0] blk, input logic lz);
        return blk[d] || (lz && d > 0 && (v >> (4 * d)) == 16'h0);
    endfunction

    // Reference model: scan position is derived from a cycle index since reset.
    int          m_cyc, m_t, m_dig, m_step;
    logic        m_bnd, m_lit, m_pend;
    logic [15:0] m_data, p_data;
    logic [3:0]  m_dp, m_blank, p_dp, p_blank;
    logic [3:0]  e_an;
    logic [6:0]  e_seg;
    logic        e_dp, e_fs;

    always_comb begin
        m_t    = m_cyc % FRAME;
        m_dig  = m_t / SLOT;
        m_step = (m_t % SLOT) / TD;
        m_bnd  = (m_t == FRAME - 1);
        m_lit  = (m_step >= 1) && (m_step <= int'(bright)) &&
                 !ref_dark(m_dig, m_data, m_blank, lz_en);
    end

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_cyc <= 0; m_pend <= 1'b0;
            m_data <= '0; m_dp <= '0; m_blank <= '0;
            p_data <= '0; p_dp <= '0; p_blank <= '0;
            e_an <= 4'hF; e_seg <= 7'h7F; e_dp <= 1'b1; e_fs <= 1'b0;
        end else begin
            e_an  <= m_lit ? ~(4'b0001 << m_dig) : 4'hF;
            e_seg <= m_lit ? ref_glyph(nib(m_data, m_dig)) : 7'h7F;
            e_dp  <= !(m_lit && m_dp[m_dig]);
            e_fs  <= m_bnd;
            m_cyc <= (m_cyc + 1) % FRAME;
            if (load && m_bnd) begin
                m_data <= data_in; m_dp <= dp_in; m_blank <= blank_in; m_pend <= 1'b0;
            end else begin
                if (m_bnd && m_pend) begin
                    m_data <= p_data; m_dp <= p_dp; m_blank <= p_blank; m_pend <= 1'b0;
                end
                if (load) begin
                    p_data <= data_in; p_dp <= dp_in; p_blank <= blank_in; m_pend <= 1'b1;
                end
            end
        end
    end

    int         low_cnt [4];
    int         dp_low  [4];
    logic [6:0] seen_seg [4];

    task automatic do_load(input logic [15:0] d, input logic [3:0] dp, input logic [3:0] bl);
        data_in = d; dp_in = dp; blank_in = bl; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic run_frame();
        for (int d = 0; d < 4; d++) begin
            low_cnt[d] = 0; dp_low[d] = 0; seen_seg[d] = 7'h7F;
        end
        repeat (FRAME) begin
            @(negedge clk);
            for (int d = 0; d < 4; d++) begin
                if (!anode_n[d]) begin
                    low_cnt[d]++;
                    seen_seg[d] = seg_n;
                    if (!dp_n) dp_low[d]++;
                end
            end
        end
    endtask

    task automatic wait_fs();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_start && n < 3 * FRAME);
        total++;
        if (frame_start !== 1'b1) begin
            bad++;
            $display("FAIL frame_start_timeout: waited %0d cycles, frame_start=%b required 1", n, frame_start);
        end
    endtask

    task automatic test_reset();
        int n = 0;
        repeat (50) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        total++; if (anode_n !== 4'hF) begin bad++; $display("FAIL reset_anode: got %h want f", anode_n); end
        total++; if (seg_n !== 7'h7F) begin bad++; $display("FAIL reset_seg: got %h want 7f", seg_n); end
        total++; if (dp_n !== 1'b1) begin bad++; $display("FAIL reset_dp: got %b want 1", dp_n); end
        total++; if (frame_start !== 1'b0) begin bad++; $display("FAIL reset_fs: got %b want 0", frame_start); end
        @(negedge clk);
        reset = 1'b0;
        do begin
            @(negedge clk);
            n++;
        end while (anode_n === 4'hF && n < 10);
        total++; if (n != 3) begin bad++; $display("FAIL reset_first_lit_cycle: got %0d want 3", n); end
        total++; if (anode_n !== 4'b1110) begin bad++; $display("FAIL reset_first_anode: got %b want 1110", anode_n); end
        total++; if (seg_n !== 7'b0000001) begin bad++; $display("FAIL reset_first_seg: got %b want 0000001", seg_n); end
    endtask

    task automatic test_glyphs();
        logic [6:0] exp_g [4];
        exp_g = '{7'b0000000, 7'b0000001, 7'b0111000, 7'b0000110};
        lz_en = 1'b0; bright = 4'd15;
        do_load(16'h3F08, 4'h0, 4'h0);
        wait_fs();
        run_frame();
        for (int d = 0; d < 4; d++) begin
            total++;
            if (low_cnt[d] != 30) begin bad++; $display("FAIL glyph_low_cnt[%0d]: got %0d want 30", d, low_cnt[d]); end
            total++;
            if (seen_seg[d] !== exp_g[d]) begin bad++; $display("FAIL glyph_seg[%0d]: got %b want %b", d, seen_seg[d], exp_g[d]); end
        end
    endtask

    task automatic test_lz();
        int exp1 [4];
        int exp2 [4];
        exp1 = '{30, 30, 0, 0};
        exp2 = '{30, 0, 0, 0};
        lz_en = 1'b1;
        do_load(16'h0040, 4'h0, 4'h0);
        wait_fs();
        run_frame();
        for (int d = 0; d < 4; d++) begin
            total++;
            if (low_cnt[d] != exp1[d]) begin bad++; $display("FAIL lz_low_cnt[%0d]: got %0d want %0d", d, low_cnt[d], exp1[d]); end
        end
        total++; if (seen_seg[1] !== 7'b1001100) begin bad++; $display("FAIL lz_seg1: got %b want 1001100", seen_seg[1]); end
        total++; if (seen_seg[0] !== 7'b0000001) begin bad++; $display("FAIL lz_seg0: got %b want 0000001", seen_seg[0]); end
        do_load(16'h0000, 4'h0, 4'h0);
        wait_fs();
        run_frame();
        for (int d = 0; d < 4; d++) begin
            total++;
            if (low_cnt[d] != exp2[d]) begin bad++; $display("FAIL lz_zero_low_cnt[%0d]: got %0d want %0d", d, low_cnt[d], exp2[d]); end
        end
        lz_en = 1'b0;
    endtask

    task automatic test_brightness();
        do_load(16'h1234, 4'h0, 4'h0);
        wait_fs();
        bright = 4'd4;
        run_frame();
        for (int d = 0; d < 4; d++) begin
            total++;
            if (low_cnt[d] != 8) begin bad++; $display("FAIL bright4_low_cnt[%0d]: got %0d want 8", d, low_cnt[d]); end
        end
        bright = 4'd0;
        run_frame();
        total++;
        if (low_cnt[0] + low_cnt[1] + low_cnt[2] + low_cnt[3] != 0) begin
            bad++; $display("FAIL bright0_low_total: got %0d want 0", low_cnt[0] + low_cnt[1] + low_cnt[2] + low_cnt[3]);
        end
        bright = 4'd15;
    endtask

    task automatic test_buffering();
        logic [15:0] a, b, c;
        int stale_err = 0;
        int n = 0;
        a = 16'($urandom); b = 16'($urandom); c = ~b;
        wait_fs();
        repeat (20) @(negedge clk);
        do_load(a, 4'h0, 4'h0);
        repeat (20) @(negedge clk);
        do_load(b, 4'h0, 4'h0);
        while (!frame_start && n < FRAME) begin
            for (int d = 0; d < 4; d++)
                if (!anode_n[d] && seg_n !== ref_glyph(nib(16'h1234, d))) stale_err++;
            @(negedge clk);
            n++;
        end
        total++; if (stale_err != 0) begin bad++; $display("FAIL buf_early_update: %0d stale-glyph errors, want 0", stale_err); end
        run_frame();
        for (int d = 0; d < 4; d++) begin
            total++;
            if (seen_seg[d] !== ref_glyph(nib(b, d))) begin
                bad++; $display("FAIL buf_last_wins[%0d]: got %b want %b", d, seen_seg[d], ref_glyph(nib(b, d)));
            end
        end
        wait_fs();
        repeat (FRAME - 1) @(negedge clk);
        do_load(c, 4'h0, 4'h0);
        total++; if (frame_start !== 1'b1) begin bad++; $display("FAIL buf_boundary_align: frame_start=%b want 1", frame_start); end
        run_frame();
        for (int d = 0; d < 4; d++) begin
            total++;
            if (seen_seg[d] !== ref_glyph(nib(c, d))) begin
                bad++; $display("FAIL buf_boundary_load[%0d]: got %b want %b", d, seen_seg[d], ref_glyph(nib(c, d)));
            end
        end
    endtask

    task automatic test_dp_blank();
        int exp_dp [4];
        exp_dp = '{0, 30, 0, 0};
        for (int k = 0; k < 2; k++) begin
            do_load(16'($urandom), (k == 0) ? 4'b0010 : 4'b0011, 4'b0001);
            wait_fs();
            run_frame();
            total++; if (low_cnt[0] != 0) begin bad++; $display("FAIL blank0_low_cnt[k%0d]: got %0d want 0", k, low_cnt[0]); end
            for (int d = 0; d < 4; d++) begin
                total++;
                if (dp_low[d] != exp_dp[d]) begin bad++; $display("FAIL dp_low[k%0d][%0d]: got %0d want %0d", k, d, dp_low[d], exp_dp[d]); end
            end
        end
    endtask

    task automatic test_random();
        int shown = 0;
        for (int r = 0; r < 6; r++) begin
            lz_en  = 1'($urandom);
            bright = 4'($urandom);
            for (int c = 0; c < 300; c++) begin
                @(negedge clk);
                total++;
                if ({anode_n, seg_n, dp_n, frame_start} !== {e_an, e_seg, e_dp, e_fs}) begin
                    bad++;
                    if (shown < 10) begin
                        shown++;
                        $display("FAIL random_cycle r%0d c%0d: an=%b seg=%b dp=%b fs=%b want an=%b seg=%b dp=%b fs=%b",
                                 r, c, anode_n, seg_n, dp_n, frame_start, e_an, e_seg, e_dp, e_fs);
                    end
                end
                load = ($urandom_range(0, 39) == 0);
                if (load) begin
                    data_in  = 16'($urandom);
                    dp_in    = 4'($urandom);
                    blank_in = 4'($urandom) & 4'($urandom);
                    if ($urandom_range(0, 1) == 1) data_in = data_in & 16'h00FF;
                end
                if ($urandom_range(0, 99) == 0) bright = 4'($urandom);
            end
            load = 1'b0;
        end
    endtask

    initial begin
        clk = 1'b0; reset = 1'b1;
        data_in = '0; dp_in = '0; blank_in = '0;
        lz_en = 1'b0; bright = 4'd15; load = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        test_reset();
        test_glyphs();
        test_lz();
        test_brightness();
        test_buffering();
        test_dp_blank();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
